// File: rtl/wshb_intercon_rr.sv
// wshb_intercon_rr: round-robin Wishbone arbiter, NB_MASTERS m_* ports onto one s_* slave, grant held per cyc, optional ack watchdog
module wshb_intercon_rr #(
    parameter int NB_MASTERS = 2,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int TIMEOUT    = 0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NB_MASTERS-1:0]            m_cyc,
    input  logic [NB_MASTERS-1:0]            m_stb,
    input  logic [NB_MASTERS-1:0]            m_we,
    input  logic [NB_MASTERS*ADDR_W-1:0]     m_adr,
    input  logic [NB_MASTERS*DATA_W-1:0]     m_dat_ms,
    input  logic [NB_MASTERS*DATA_W/8-1:0]   m_sel,
    input  logic [NB_MASTERS*3-1:0]          m_cti,
    input  logic [NB_MASTERS*2-1:0]          m_bte,
    output logic [NB_MASTERS-1:0]            m_ack,
    output logic [NB_MASTERS-1:0]            m_err,
    output logic [NB_MASTERS-1:0]            m_rty,
    output logic [DATA_W-1:0]                m_dat_sm,
    output logic                             s_cyc,
    output logic                             s_stb,
    output logic                             s_we,
    output logic [ADDR_W-1:0]                s_adr,
    output logic [DATA_W-1:0]                s_dat_ms,
    output logic [DATA_W/8-1:0]              s_sel,
    output logic [2:0]                       s_cti,
    output logic [1:0]                       s_bte,
    input  logic                             s_ack,
    input  logic                             s_err,
    input  logic                             s_rty,
    input  logic [DATA_W-1:0]                s_dat_sm,
    output logic                             grant_valid,
    output logic [$clog2(NB_MASTERS)-1:0]    grant_idx,
    output logic                             timeout_evt
);
    localparam int IW   = $clog2(NB_MASTERS);
    localparam int TLIM = TIMEOUT > 0 ? TIMEOUT - 1 : 0;
    localparam int CW   = TLIM > 0 ? $clog2(TLIM + 1) : 1;
    logic [IW-1:0]         last, nxt, cand;
    logic                  found, hold, act, stall, expire;
    logic [CW-1:0]         cnt;
    logic [NB_MASTERS-1:0] oh;
    always_comb begin
        nxt   = '0;
        cand  = '0;
        found = 1'b0;
        for (int k = 1; k <= NB_MASTERS; k++) begin
            cand = IW'((int'(last) + k) % NB_MASTERS);
            if (!found && m_cyc[cand]) begin
                found = 1'b1;
                nxt   = cand;
            end
        end
    end
    assign hold        = grant_valid & m_cyc[grant_idx];
    assign act         = hold & m_stb[grant_idx];
    assign stall       = act & ~(s_ack | s_err | s_rty);
    assign expire      = TIMEOUT > 0 && !rst && stall && cnt == CW'(TLIM);
    assign oh          = NB_MASTERS'(1) << grant_idx;
    assign s_cyc       = hold;
    assign s_stb       = act & ~expire;
    assign s_we        = m_we[grant_idx];
    assign s_adr       = m_adr[grant_idx*ADDR_W +: ADDR_W];
    assign s_dat_ms    = m_dat_ms[grant_idx*DATA_W +: DATA_W];
    assign s_sel       = m_sel[grant_idx*(DATA_W/8) +: DATA_W/8];
    assign s_cti       = m_cti[grant_idx*3 +: 3];
    assign s_bte       = m_bte[grant_idx*2 +: 2];
    assign m_ack       = act && s_ack ? oh : '0;
    assign m_err       = (act && s_err) || expire ? oh : '0;
    assign m_rty       = act && s_rty ? oh : '0;
    assign m_dat_sm    = s_dat_sm;
    assign timeout_evt = expire;
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_valid <= 1'b0;
            grant_idx   <= '0;
            last        <= IW'(NB_MASTERS - 1);
            cnt         <= '0;
        end else begin
            if (!hold) begin
                grant_valid <= found;
                if (found) begin
                    grant_idx <= nxt;
                    last      <= nxt;
                end
            end
            cnt <= TIMEOUT > 0 && stall && !expire ? cnt + 1'b1 : '0;
        end
    end
endmodule

// File: tb/tb_wshb_intercon_rr.sv
// tb_wshb_intercon_rr: directed checks of grant order, bursts, single reads, watchdog and reset for wshb_intercon_rr
module tb_wshb_intercon_rr;
    logic        clk = 1'b0, rst = 1'b1;
    logic [2:0]  m_cyc = '0, m_stb = '0, m_we = '0;
    logic [95:0] m_adr = '0, m_dat_ms = '0;
    logic [11:0] m_sel = '0;
    logic [8:0]  m_cti = '0;
    logic [5:0]  m_bte = '0;
    logic [2:0]  m_ack, m_err, m_rty;
    logic [31:0] m_dat_sm, s_adr, s_dat_ms;
    logic        s_cyc, s_stb, s_we;
    logic [3:0]  s_sel;
    logic [2:0]  s_cti;
    logic [1:0]  s_bte;
    logic        s_ack = 1'b0, s_err = 1'b0, s_rty = 1'b0;
    logic [31:0] s_dat_sm = '0;
    logic        grant_valid, timeout_evt;
    logic [1:0]  grant_idx;
    int vecs = 0, errs = 0;

    wshb_intercon_rr #(.NB_MASTERS(3), .ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_adr(m_adr),
        .m_dat_ms(m_dat_ms), .m_sel(m_sel), .m_cti(m_cti), .m_bte(m_bte), .m_ack(m_ack),
        .m_err(m_err), .m_rty(m_rty), .m_dat_sm(m_dat_sm), .s_cyc(s_cyc), .s_stb(s_stb),
        .s_we(s_we), .s_adr(s_adr), .s_dat_ms(s_dat_ms), .s_sel(s_sel), .s_cti(s_cti),
        .s_bte(s_bte), .s_ack(s_ack), .s_err(s_err), .s_rty(s_rty), .s_dat_sm(s_dat_sm),
        .grant_valid(grant_valid), .grant_idx(grant_idx), .timeout_evt(timeout_evt)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        tick();
        tick();
        #1;
        vecs++; if (grant_valid !== 1'b0) begin errs++; $display("FAIL rst_gv got %b want 0", grant_valid); end
        vecs++; if (grant_idx !== 2'd0) begin errs++; $display("FAIL rst_gidx got %0d want 0", grant_idx); end
        vecs++; if ({s_cyc, s_stb} !== 2'b00) begin errs++; $display("FAIL rst_scyc got %b want 00", {s_cyc, s_stb}); end
        vecs++; if ({m_ack, m_err, m_rty, timeout_evt} !== 10'd0) begin errs++; $display("FAIL rst_resp got %b want 0", {m_ack, m_err, m_rty, timeout_evt}); end
        rst = 1'b0;
    endtask

    task automatic test_rr_order;
        for (int i = 0; i < 3; i++) m_adr[i*32 +: 32] = 32'h100 * (i + 1);
        m_cyc = 3'b111;
        m_stb = 3'b111;
        #1;
        vecs++; if (s_cyc !== 1'b0) begin errs++; $display("FAIL rr_pre_scyc got %b want 0", s_cyc); end
        tick();
        vecs++; if ({grant_valid, grant_idx, s_cyc} !== 4'b1001) begin errs++; $display("FAIL rr_g0 got %b want 1001", {grant_valid, grant_idx, s_cyc}); end
        vecs++; if (s_adr !== 32'h100) begin errs++; $display("FAIL rr_adr0 got %h want 100", s_adr); end
        tick();
        vecs++; if (grant_idx !== 2'd0) begin errs++; $display("FAIL rr_keep0 got %0d want 0", grant_idx); end
        m_cyc[0] = 1'b0;
        m_stb[0] = 1'b0;
        #1;
        vecs++; if (s_cyc !== 1'b0) begin errs++; $display("FAIL rr_drop_scyc got %b want 0", s_cyc); end
        tick();
        vecs++; if ({grant_idx, s_cyc} !== 3'b011) begin errs++; $display("FAIL rr_g1 got %b want 011", {grant_idx, s_cyc}); end
        vecs++; if (s_adr !== 32'h200) begin errs++; $display("FAIL rr_adr1 got %h want 200", s_adr); end
        m_cyc[1] = 1'b0;
        m_stb[1] = 1'b0;
        tick();
        vecs++; if ({grant_idx, s_cyc, s_adr} !== {3'b101, 32'h300}) begin errs++; $display("FAIL rr_g2 got %b/%h want 101/300", {grant_idx, s_cyc}, s_adr); end
        m_cyc[2] = 1'b0;
        m_stb[2] = 1'b0;
        tick();
        vecs++; if ({grant_valid, s_cyc} !== 2'b00) begin errs++; $display("FAIL rr_idle got %b want 00", {grant_valid, s_cyc}); end
    endtask

    task automatic test_burst;
        m_cyc[1] = 1'b1;
        m_stb[1] = 1'b1;
        m_cti[5:3] = 3'b010;
        tick();
        vecs++; if (grant_idx !== 2'd1) begin errs++; $display("FAIL bu_g1 got %0d want 1", grant_idx); end
        m_cyc[0] = 1'b1;
        m_stb[0] = 1'b1;
        for (int b = 0; b < 8; b++) begin
            s_ack = 1'b1;
            s_dat_sm = 32'hB000 + b;
            #1;
            vecs++; if ({m_ack, grant_idx, s_cti} !== 8'b010_01_010) begin errs++; $display("FAIL bu_beat%0d got %b want 01001010", b, {m_ack, grant_idx, s_cti}); end
            vecs++; if (m_dat_sm !== 32'hB000 + b) begin errs++; $display("FAIL bu_dat%0d got %h want %h", b, m_dat_sm, 32'hB000 + b); end
            tick();
        end
        s_ack = 1'b0;
        m_cyc[1] = 1'b0;
        m_stb[1] = 1'b0;
        m_cti = '0;
        #1;
        vecs++; if (s_cyc !== 1'b0) begin errs++; $display("FAIL bu_rel_scyc got %b want 0", s_cyc); end
        tick();
        vecs++; if ({grant_idx, s_cyc} !== 3'b001) begin errs++; $display("FAIL bu_g0 got %b want 001", {grant_idx, s_cyc}); end
        m_cyc[0] = 1'b0;
        m_stb[0] = 1'b0;
        tick();
    endtask

    task automatic test_single_reads;
        m_cyc[2] = 1'b1;
        m_stb[2] = 1'b1;
        m_adr[64 +: 32] = 32'hCAFE0000;
        m_sel[11:8] = 4'hF;
        #1;
        vecs++; if (s_cyc !== 1'b0) begin errs++; $display("FAIL sr_pre got %b want 0", s_cyc); end
        tick();
        vecs++; if ({s_cyc, grant_idx, s_sel, s_we} !== 8'b1_10_1111_0) begin errs++; $display("FAIL sr_grant got %b want 11011110", {s_cyc, grant_idx, s_sel, s_we}); end
        for (int r = 0; r < 4; r++) begin
            s_ack = 1'b1;
            s_dat_sm = 32'h5A5A0000 + r;
            #1;
            vecs++; if ({m_ack, m_dat_sm} !== {3'b100, 32'h5A5A0000 + r}) begin errs++; $display("FAIL sr_ack%0d got %b/%h want 100/%h", r, m_ack, m_dat_sm, 32'h5A5A0000 + r); end
            tick();
            s_ack = 1'b0;
            #1;
            vecs++; if (m_ack !== 3'b000) begin errs++; $display("FAIL sr_noack%0d got %b want 000", r, m_ack); end
            tick();
        end
        m_cyc[2] = 1'b0;
        m_stb[2] = 1'b0;
        tick();
    endtask

    task automatic test_timeout;
        m_cyc[0] = 1'b1;
        m_stb[0] = 1'b1;
        tick();
        for (int n = 1; n < 16; n++) begin
            #1;
            vecs++; if ({m_err, timeout_evt, s_stb} !== 5'b000_0_1) begin errs++; $display("FAIL to_stall%0d got %b want 00001", n, {m_err, timeout_evt, s_stb}); end
            tick();
        end
        vecs++; if ({m_err, timeout_evt, s_stb} !== 5'b001_1_0) begin errs++; $display("FAIL to_expire got %b want 00110", {m_err, timeout_evt, s_stb}); end
        tick();
        vecs++; if ({m_err, timeout_evt, s_stb} !== 5'b000_0_1) begin errs++; $display("FAIL to_restart got %b want 00001", {m_err, timeout_evt, s_stb}); end
        m_cyc[0] = 1'b0;
        m_stb[0] = 1'b0;
        tick();
    endtask

    task automatic test_ack_at_limit;
        m_cyc[1] = 1'b1;
        m_stb[1] = 1'b1;
        tick();
        vecs++; if (grant_idx !== 2'd1) begin errs++; $display("FAIL al_g1 got %0d want 1", grant_idx); end
        for (int n = 1; n < 16; n++) tick();
        s_ack = 1'b1;
        #1;
        vecs++; if ({m_ack, m_err, timeout_evt, s_stb} !== 8'b010_000_0_1) begin errs++; $display("FAIL al_ack got %b want 01000001", {m_ack, m_err, timeout_evt, s_stb}); end
        tick();
        s_ack = 1'b0;
        m_cyc[1] = 1'b0;
        m_stb[1] = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_burst;
        m_cyc[2] = 1'b1;
        m_stb[2] = 1'b1;
        m_cti[8:6] = 3'b010;
        tick();
        vecs++; if (grant_idx !== 2'd2) begin errs++; $display("FAIL rb_g2 got %0d want 2", grant_idx); end
        s_ack = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        m_cyc = 3'b111;
        m_stb = 3'b111;
        tick();
        vecs++; if ({grant_valid, s_cyc, m_ack, m_err, timeout_evt} !== 9'd0) begin errs++; $display("FAIL rb_drop got %b want 0", {grant_valid, s_cyc, m_ack, m_err, timeout_evt}); end
        rst = 1'b0;
        s_ack = 1'b0;
        tick();
        vecs++; if ({grant_valid, grant_idx} !== 3'b100) begin errs++; $display("FAIL rb_first got %b want 100", {grant_valid, grant_idx}); end
        m_cyc = '0;
        m_stb = '0;
        m_cti = '0;
        tick();
    endtask

    initial begin
        test_reset();
        test_rr_order();
        test_burst();
        test_single_reads();
        test_timeout();
        test_ack_at_limit();
        test_reset_mid_burst();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
